// File: rtl/thermocouple_spi_responder.sv
// thermocouple_spi_responder: MAX31855-style SPI responder that shifts a 32-bit temperature/fault frame on miso.
// Optional THERMOCOUPLE_FAULT_STICKY_EN latches fault inputs until the next frame completes.
module thermocouple_spi_responder #(
    parameter int CONV_CYCLES = 200,
    parameter int CBITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] tc_temp,
    input  logic [11:0] junction_temp,
    input  logic        fault_oc,
    input  logic        fault_scg,
    input  logic        fault_scv,
    input  logic        sck,
    input  logic        cs_n,
    output logic        miso,
    output logic        miso_oe,
    output logic        conv_busy,
    output logic        frame_done
);
    typedef enum logic [1:0] {CONV, READY, SHIFT} state_t;
    state_t state;
    logic [CBITS-1:0] cnt;
    logic [31:0] snapshot, sr, frame;
    logic [5:0] bcnt;
    logic [1:0] cs_q, sck_q;
    logic cs_d, sck_d, cs_s, sck_s, cs_fall, cs_rise, sck_fall;
    logic [2:0] f;
    assign cs_s = cs_q[1];
    assign sck_s = sck_q[1];
    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;
    assign sck_fall = sck_d & ~sck_s;
`ifdef THERMOCOUPLE_FAULT_STICKY_EN
    logic [2:0] sticky;
    always_ff @(posedge clk)
        if (rst || frame_done) sticky <= '0;
        else sticky <= sticky | {fault_scv, fault_scg, fault_oc};
    assign f = sticky;
`else
    assign f = {fault_scv, fault_scg, fault_oc};
`endif
    assign frame = {tc_temp, 1'b0, |f, junction_temp, 1'b0, f};
    assign miso_oe = ~cs_s;
    assign conv_busy = state == CONV;
    // Bit 31 must be on miso in the very cycle the falling cs_n is seen, before sr is loaded.
    assign miso = ~cs_s & (state == SHIFT ? sr[31] & ~bcnt[5] : snapshot[31]);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CONV;
            cnt <= '0;
            snapshot <= '0;
            sr <= '0;
            bcnt <= '0;
            frame_done <= 1'b0;
            cs_q <= 2'b11;
            cs_d <= 1'b1;
            sck_q <= 2'b00;
            sck_d <= 1'b0;
        end else begin
            cs_q <= {cs_q[0], cs_n};
            cs_d <= cs_s;
            sck_q <= {sck_q[0], sck};
            sck_d <= sck_s;
            frame_done <= 1'b0;
            case (state)
                CONV: begin
                    if (cs_fall) begin
                        state <= SHIFT;
                        sr <= snapshot;
                        bcnt <= '0;
                    end else if (cnt == CBITS'(CONV_CYCLES - 1)) begin
                        snapshot <= frame;
                        cnt <= '0;
                        state <= READY;
                    end else cnt <= cnt + 1'b1;
                end
                READY: begin
                    if (cs_fall) begin
                        state <= SHIFT;
                        sr <= snapshot;
                        bcnt <= '0;
                    end
                end
                default: begin
                    if (cs_rise) begin
                        state <= CONV;
                        cnt <= '0;
                    end else if (sck_fall && !bcnt[5]) begin
                        sr <= {sr[30:0], 1'b0};
                        bcnt <= bcnt + 1'b1;
                        frame_done <= bcnt == 6'd31;
                    end
                end
            endcase
        end
    end
endmodule
